// File: rtl/fft_pkg.sv
// Shared widths and serializer state for the demux datapath.
// Lane k of a packed bus occupies bits [k*WORD_W +: WORD_W].
package fft_pkg;
  localparam int WORD_W    = 34;
  localparam int LANES     = 4;
  localparam int BUS_W     = WORD_W * LANES;
  localparam int FRAME_LEN = 16;
  localparam int CNT_W     = $clog2(FRAME_LEN);

  typedef enum logic {
    S_IDLE,
    S_SHIFT
  } ser_state_t;
endpackage

// File: rtl/demux_serializer.sv
// Captures one packed bus and emits its lanes, lane 0 first,
// one word per clock.
module demux_serializer #(
  parameter int WORD_W = 34,
  parameter int LANES  = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_cap,
  input  logic [WORD_W*LANES-1:0]   i_data,
  output logic [WORD_W-1:0]         o_data,
  output logic                      o_valid
);
  import fft_pkg::ser_state_t;
  import fft_pkg::S_IDLE;
  import fft_pkg::S_SHIFT;

  localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(LANES - 1);

  ser_state_t                  r_state;
  ser_state_t                  w_next;
  logic [WORD_W*LANES-1:0]     r_buf;
  logic [IDX_W-1:0]            r_idx;
  logic [WORD_W-1:0]           w_lane;

  assign w_lane = r_buf[int'(r_idx)*WORD_W +: WORD_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (i_cap) w_next = S_SHIFT;
      S_SHIFT: if (r_idx == LAST) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // A capture can only arrive in IDLE: a frame is far longer
  // than the LANES cycles spent shifting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_buf   <= '0;
      r_idx   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      if (r_state == S_SHIFT) begin
        o_data  <= w_lane;
        o_valid <= 1'b1;
        r_idx   <= (r_idx == LAST) ? '0 : r_idx + 1'b1;
      end else if (i_cap) begin
        r_buf <= i_data;
        r_idx <= '0;
      end
    end
  end
endmodule

// File: rtl/demux.sv
// Frame counter plus registered two-way router; one slot per
// frame diverts the bus into the lane serializer instead.
module demux #(
  parameter int WORD_W       = fft_pkg::WORD_W,
  parameter int LANES        = fft_pkg::LANES,
  parameter int CAPTURE_SLOT = 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     demux_flag,
  input  logic                     in_valid,
  input  logic [WORD_W*LANES-1:0]  data_in,
  output logic [WORD_W*LANES-1:0]  data_out_1,
  output logic                     valid_out_1,
  output logic [WORD_W*LANES-1:0]  data_out_2,
  output logic                     valid_out_2,
  output logic [WORD_W-1:0]        data_out_3,
  output logic                     valid_out_3,
  output logic                     frame_sync
);
  import fft_pkg::CNT_W;

  localparam logic [CNT_W-1:0] CAP = CNT_W'(CAPTURE_SLOT);

  logic [CNT_W-1:0] r_cnt;
  logic             w_slot;
  logic             w_cap;

  assign w_slot     = (r_cnt == CAP);
  assign w_cap      = in_valid && w_slot;
  assign frame_sync = (r_cnt == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_cnt <= '0;
    else        r_cnt <= r_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_out_1  <= '0;
      data_out_2  <= '0;
      valid_out_1 <= 1'b0;
      valid_out_2 <= 1'b0;
    end else begin
      valid_out_1 <= 1'b0;
      valid_out_2 <= 1'b0;
      if (in_valid && !w_slot) begin
        if (demux_flag) begin
          data_out_1  <= data_in;
          valid_out_1 <= 1'b1;
        end else begin
          data_out_2  <= data_in;
          valid_out_2 <= 1'b1;
        end
      end
    end
  end

  demux_serializer #(
    .WORD_W (WORD_W),
    .LANES  (LANES)
  ) u_ser (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_cap   (w_cap),
    .i_data  (data_in),
    .o_data  (data_out_3),
    .o_valid (valid_out_3)
  );
endmodule

// File: tb/tb_demux.sv
// Self-checking bench for demux: a behavioural frame model
// queues per-cycle expectations that are checked after each edge.
module tb_demux;
  localparam int W = 34;
  localparam int L = 4;
  localparam int B = W * L;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         demux_flag;
  logic         in_valid;
  logic [B-1:0] data_in;
  logic [B-1:0] data_out_1;
  logic         valid_out_1;
  logic [B-1:0] data_out_2;
  logic         valid_out_2;
  logic [W-1:0] data_out_3;
  logic         valid_out_3;
  logic         frame_sync;

  demux #(
    .WORD_W       (W),
    .LANES        (L),
    .CAPTURE_SLOT (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .demux_flag  (demux_flag),
    .in_valid    (in_valid),
    .data_in     (data_in),
    .data_out_1  (data_out_1),
    .valid_out_1 (valid_out_1),
    .data_out_2  (data_out_2),
    .valid_out_2 (valid_out_2),
    .data_out_3  (data_out_3),
    .valid_out_3 (valid_out_3),
    .frame_sync  (frame_sync)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [B-1:0] d1;
    logic [B-1:0] d2;
    logic         v1;
    logic         v2;
    logic [W-1:0] d3;
    logic         v3;
    logic         fs;
  } exp_t;

  exp_t sb[$];

  int total = 0;
  int bad   = 0;

  int           m_cnt;
  logic [B-1:0] m_d1, m_d2, m_buf;
  logic [W-1:0] m_d3;
  logic         m_shift;
  int           m_idx;

  task automatic chk(input string tag, input logic [B-1:0] got,
                     input logic [B-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s cnt=%0d got=%h exp=%h", tag, m_cnt, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_d1 = '0; m_d2 = '0; m_buf = '0;
    m_d3 = '0; m_shift = 1'b0; m_idx = 0;
    sb.delete();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_d1"}, data_out_1, '0);
    chk({tag, "_d2"}, data_out_2, '0);
    chk({tag, "_d3"}, B'(data_out_3), '0);
    chk({tag, "_v"}, B'({valid_out_1, valid_out_2, valid_out_3}), '0);
    chk({tag, "_fs"}, B'(frame_sync), B'(1));
  endtask

  function automatic logic [B-1:0] rnd();
    logic [159:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    return t[B-1:0];
  endfunction

  // Called at a falling edge: drive, predict, clock, compare.
  task automatic step(input logic f, input logic v,
                      input logic [B-1:0] d);
    exp_t e;
    demux_flag = f; in_valid = v; data_in = d;
    e.v1 = 1'b0; e.v2 = 1'b0; e.v3 = 1'b0;
    if (v && m_cnt != 2) begin
      if (f) begin m_d1 = d; e.v1 = 1'b1; end
      else   begin m_d2 = d; e.v2 = 1'b1; end
    end
    if (m_shift) begin
      m_d3 = m_buf[m_idx*W +: W];
      e.v3 = 1'b1;
      m_idx++;
      if (m_idx == L) m_shift = 1'b0;
    end else if (v && m_cnt == 2) begin
      m_buf = d; m_shift = 1'b1; m_idx = 0;
    end
    m_cnt = (m_cnt + 1) % 16;
    e.d1 = m_d1; e.d2 = m_d2; e.d3 = m_d3;
    e.fs = (m_cnt == 0);
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    e = sb.pop_front();
    chk("d1", data_out_1, e.d1);
    chk("v1", B'(valid_out_1), B'(e.v1));
    chk("d2", data_out_2, e.d2);
    chk("v2", B'(valid_out_2), B'(e.v2));
    chk("d3", B'(data_out_3), B'(e.d3));
    chk("v3", B'(valid_out_3), B'(e.v3));
    chk("fs", B'(frame_sync), B'(e.fs));
  endtask

  task automatic idle_to(input int c);
    for (int n = 0; n < 16 && m_cnt != c; n++) step(1'b0, 1'b0, '0);
  endtask

  logic [B-1:0] lanes;
  logic [B-1:0] a5;

  initial begin
    rst_n = 1'b0; demux_flag = 1'b0; in_valid = 1'b0; data_in = '0;
    lanes = {34'h3_0000_0003, 34'h2_0000_0002,
             34'h1_0000_0001, 34'h0_0000_0000};
    a5 = {17{8'hA5}};
    model_reset();
    #3;
    chk_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;
    chk("fs_rel", B'(frame_sync), B'(1));

    for (int i = 0; i < 32; i++) step(1'b0, 1'b0, '0);

    idle_to(5);
    step(1'b1, 1'b1, a5);

    idle_to(2);
    step(1'b1, 1'b1, lanes);
    for (int i = 0; i < 4; i++) step(i[0], 1'b1, rnd());
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0);

    idle_to(0);
    for (int i = 0; i < 16; i++)
      step(1'($urandom), (m_cnt == 2) ? 1'b0 : 1'($urandom), rnd());

    idle_to(2);
    step(1'b0, 1'b1, rnd());
    idle_to(5);
    #2 rst_n = 1'b0;
    #1 chk_zero("arst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    chk("fs_rel2", B'(frame_sync), B'(1));
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, '0);

    for (int i = 0; i < 80; i++)
      step(1'($urandom), 1'($urandom), rnd());

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
